axis_split_len_scheduler: RTL and testbench

Sequences axi_stream_split_channel by supplying one split length per origin packet. Lengths are queued by software or upstream logic. The block gates the origin stream so a packet only enters the splitter once its split_len is loaded. split_len is held constant from the first beat through the tlast handshake of that packet.

---
 rtl/axis_split_sched_pkg.sv | 13 +
 rtl/axis_split_len_fifo.sv | 59 +++++
 rtl/axis_split_len_scheduler.sv | 121 ++++++++++++
 tb/tb_axis_split_len_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_split_sched_pkg.sv
// Shared types for the split-length scheduler.
// FSM encoding and default sizing.
package axis_split_sched_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  localparam int DEF_LSIZE = 16;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/axis_split_len_fifo.sv
// Show-ahead synchronous FIFO holding queued split lengths.
// A push while full is taken only when a pop frees the slot.
module axis_split_len_fifo
  import axis_split_sched_pkg::*;
#(
  parameter int WIDTH = DEF_LSIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clock,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));
  assign count = cnt_q;
  assign dout  = mem_q[rd_q];

  always_comb begin
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d   = cnt_q;
    if (do_push && !do_pop) cnt_d = cnt_q + (AW+1)'(1);
    if (do_pop && !do_push) cnt_d = cnt_q - (AW+1)'(1);
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/axis_split_len_scheduler.sv
// Gates an origin stream so each packet enters the splitter only
// once its split length is loaded; holds it until the tlast beat.
module axis_split_len_scheduler
  import axis_split_sched_pkg::*;
#(
  parameter int DSIZE = 8,
  parameter int USIZE = 1,
  parameter int LSIZE = DEF_LSIZE,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [LSIZE-1:0]       cfg_len,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DSIZE-1:0]       s_tdata,
  input  logic [USIZE-1:0]       s_tuser,
  input  logic                   s_tlast,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [DSIZE-1:0]       m_tdata,
  output logic [USIZE-1:0]       m_tuser,
  output logic                   m_tlast,
  output logic [LSIZE-1:0]       split_len,
  output logic                   pkt_done,
  output logic                   short_pkt,
  output logic [$clog2(DEPTH):0] q_count
);

  state_e           state_q, state_d;
  logic [LSIZE-1:0] split_len_q, split_len_d;
  logic [LSIZE-1:0] beat_cnt_q, beat_cnt_d;
  logic             pkt_done_q, pkt_done_d;
  logic             short_pkt_q, short_pkt_d;
  logic [LSIZE-1:0] q_dout;
  logic [LSIZE:0]   beats_now;
  logic             q_full, q_empty, q_push, pop;
  logic             active, fire, last_fire;

  axis_split_len_fifo #(
    .WIDTH (LSIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (pop),
    .din   (cfg_len),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign active    = (state_q == ACTIVE);
  assign fire      = active && s_tvalid && m_tready;
  assign last_fire = fire && s_tlast;
  assign pop       = !q_empty && (!active || last_fire);
  assign cfg_ready = rst_n && (!q_full || pop);
  assign q_push    = cfg_valid && cfg_ready;

  assign m_tvalid  = active && s_tvalid;
  assign s_tready  = active && m_tready;
  assign m_tdata   = s_tdata;
  assign m_tuser   = s_tuser;
  assign m_tlast   = s_tlast;
  assign split_len = split_len_q;
  assign pkt_done  = pkt_done_q;
  assign short_pkt = short_pkt_q;

  always_comb begin
    state_d     = state_q;
    split_len_d = split_len_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_done_d  = 1'b0;
    short_pkt_d = 1'b0;
    beats_now   = {1'b0, beat_cnt_q} + (LSIZE+1)'(1);
    unique case (state_q)
      IDLE: begin
        if (!q_empty) begin
          state_d     = ACTIVE;
          split_len_d = q_dout;
          beat_cnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (fire) begin
          if (beat_cnt_q != '1) beat_cnt_d = beat_cnt_q + LSIZE'(1);
          if (s_tlast) begin
            pkt_done_d  = 1'b1;
            // true when the packet never reached the split point
            short_pkt_d = (beats_now <= {1'b0, split_len_q});
            beat_cnt_d  = '0;
            if (!q_empty) split_len_d = q_dout;
            else          state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      split_len_q <= '0;
      beat_cnt_q  <= '0;
      pkt_done_q  <= 1'b0;
      short_pkt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      split_len_q <= split_len_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_done_q  <= pkt_done_d;
      short_pkt_q <= short_pkt_d;
    end
  end

endmodule

// File: tb/tb_axis_split_len_scheduler.sv
// Bench for axis_split_len_scheduler: directed cases plus random
// packets checked against a per-packet length/beat reference model.
module tb_axis_split_len_scheduler;

  localparam int DSIZE = 8;
  localparam int USIZE = 1;
  localparam int LSIZE = 16;
  localparam int DEPTH = 8;
  localparam int QW    = $clog2(DEPTH) + 1;
  localparam int TMO   = 200;

  logic             clock = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [LSIZE-1:0] cfg_len = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic [DSIZE-1:0] s_tdata = '0;
  logic [USIZE-1:0] s_tuser = '0;
  logic             s_tlast = 1'b0;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic [DSIZE-1:0] m_tdata;
  logic [USIZE-1:0] m_tuser;
  logic             m_tlast;
  logic [LSIZE-1:0] split_len;
  logic             pkt_done;
  logic             short_pkt;
  logic [QW-1:0]    q_count;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  axis_split_len_scheduler #(
    .DSIZE (DSIZE), .USIZE (USIZE), .LSIZE (LSIZE), .DEPTH (DEPTH)
  ) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_len   (cfg_len),
    .s_tvalid  (s_tvalid),
    .s_tready  (s_tready),
    .s_tdata   (s_tdata),
    .s_tuser   (s_tuser),
    .s_tlast   (s_tlast),
    .m_tvalid  (m_tvalid),
    .m_tready  (m_tready),
    .m_tdata   (m_tdata),
    .m_tuser   (m_tuser),
    .m_tlast   (m_tlast),
    .split_len (split_len),
    .pkt_done  (pkt_done),
    .short_pkt (short_pkt),
    .q_count   (q_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // monitor: records every accepted output beat and status pulse
  int cyc = 0;
  int obs_data[$], obs_user[$], obs_last[$], obs_len[$], obs_cyc[$];
  int n_done = 0, n_short = 0;

  always @(negedge clock) begin
    cyc++;
    if (pkt_done) n_done++;
    if (short_pkt) begin
      n_short++;
      chk("short_with_done", 32'(pkt_done), 1);
    end
    if (m_tvalid && m_tready) begin
      obs_data.push_back(int'(m_tdata));
      obs_user.push_back(int'(m_tuser));
      obs_last.push_back(int'(m_tlast));
      obs_len.push_back(int'(split_len));
      obs_cyc.push_back(cyc);
      chk("pass_data", 32'(m_tdata), 32'(s_tdata));
      chk("pass_last", 32'(m_tlast), 32'(s_tlast));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired got running required finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_hs(input bit use_cfg, output bit ok);
    int t = 0;
    bit f = 1'b0;
    while (!f && t < TMO) begin
      @(negedge clock);
      f = use_cfg ? cfg_ready : s_tready;
      step();
      t++;
    end
    ok = f;
  endtask

  task automatic push_len(input int v);
    bit ok;
    cfg_valid = 1'b1;
    cfg_len   = LSIZE'(v);
    wait_hs(1'b1, ok);
    if (!ok) chk("push_timeout", 0, 1);
    cfg_valid = 1'b0;
  endtask

  // reference model inputs: lengths pushed, length each packet should
  // see, and packet sizes in beats
  int push_lens[$], exp_lens[$], sizes[$];
  int exp_data[$], exp_user[$], exp_last[$], exp_len[$];
  bit strm_done, abort;

  task automatic cfg_drive();
    bit ok;
    foreach (push_lens[i]) begin
      cfg_valid = 1'b1;
      cfg_len   = LSIZE'(push_lens[i]);
      wait_hs(1'b1, ok);
      if (!ok) begin
        chk("cfg_timeout", 0, 1);
        break;
      end
    end
    cfg_valid = 1'b0;
  endtask

  task automatic stream_drive(input bit gaps);
    bit ok;
    foreach (sizes[i]) begin
      for (int b = 0; b < sizes[i]; b++) begin
        if (gaps && $urandom_range(0, 4) == 0) begin
          s_tvalid = 1'b0;
          step();
        end
        s_tvalid = 1'b1;
        s_tdata  = DSIZE'($urandom);
        s_tuser  = USIZE'($urandom);
        s_tlast  = (b == sizes[i] - 1);
        exp_data.push_back(int'(s_tdata));
        exp_user.push_back(int'(s_tuser));
        exp_last.push_back(int'(s_tlast));
        exp_len.push_back(exp_lens[i]);
        wait_hs(1'b0, ok);
        if (!ok) begin
          chk("stream_timeout", 0, 1);
          abort = 1'b1;
          break;
        end
      end
      if (abort) break;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic run(input bit pre, input int rdy_pct, input bit gaps,
                     input bit contig);
    int exp_short = 0;
    step();
    obs_data.delete(); obs_user.delete(); obs_last.delete();
    obs_len.delete();  obs_cyc.delete();
    exp_data.delete(); exp_user.delete(); exp_last.delete();
    exp_len.delete();
    n_done = 0; n_short = 0;
    strm_done = 1'b0; abort = 1'b0;
    foreach (sizes[i]) if (sizes[i] <= exp_lens[i]) exp_short++;
    fork
      begin
        if (pre) cfg_drive();
        stream_drive(gaps);
        strm_done = 1'b1;
      end
      begin
        if (!pre) cfg_drive();
      end
      begin
        while (!strm_done) begin
          m_tready = ($urandom_range(0, 99) < rdy_pct);
          step();
        end
      end
    join
    m_tready = 1'b0;
    step();
    step();
    chk("beats", obs_data.size(), exp_data.size());
    foreach (exp_data[i]) begin
      if (i < obs_data.size()) begin
        chk($sformatf("data[%0d]", i), obs_data[i], exp_data[i]);
        chk($sformatf("user[%0d]", i), obs_user[i], exp_user[i]);
        chk($sformatf("last[%0d]", i), obs_last[i], exp_last[i]);
        chk($sformatf("len[%0d]", i), obs_len[i], exp_len[i]);
      end
    end
    chk("pkt_done_count", n_done, sizes.size());
    chk("short_count", n_short, exp_short);
    chk("q_drained", 32'(q_count), 0);
    if (contig && obs_cyc.size() > 0)
      chk("no_bubble", obs_cyc[$] - obs_cyc[0], obs_cyc.size() - 1);
  endtask

  initial begin
    bit acc;
    // reset state, with traffic and cfg pushes held off by reset
    rst_n = 1'b0; s_tvalid = 1'b1; cfg_valid = 1'b1; cfg_len = 16'd9;
    m_tready = 1'b1;
    repeat (3) step();
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_q_count", 32'(q_count), 0);
    chk("rst_split_len", 32'(split_len), 0);
    chk("rst_pkt_done", 32'(pkt_done), 0);
    chk("rst_short_pkt", 32'(short_pkt), 0);
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_s_tready", 32'(s_tready), 0);
    cfg_valid = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_cfg_ready", 32'(cfg_ready), 1);
    chk("post_rst_q_count", 32'(q_count), 0);

    // empty-start latency
    s_tdata = 8'hA0; s_tlast = 1'b0;
    step();
    chk("idle_s_tready", 32'(s_tready), 0);
    cfg_valid = 1'b1; cfg_len = 16'd5;
    step();
    cfg_valid = 1'b0;
    chk("lat_q_count_push", 32'(q_count), 1);
    chk("lat_s_tready_push", 32'(s_tready), 0);
    chk("lat_m_tvalid_push", 32'(m_tvalid), 0);
    step();
    chk("lat_q_count_pop", 32'(q_count), 0);
    chk("lat_split_len_pop", 32'(split_len), 5);
    chk("lat_s_tready_pop", 32'(s_tready), 1);
    chk("lat_m_tvalid_pop", 32'(m_tvalid), 1);
    step();
    chk("lat_split_len_b1", 32'(split_len), 5);
    s_tdata = 8'hA1;
    step();
    s_tdata = 8'hA2; s_tlast = 1'b1;
    step();
    chk("lat_pkt_done", 32'(pkt_done), 1);
    chk("lat_short_pkt", 32'(short_pkt), 1);
    chk("lat_split_len_hold", 32'(split_len), 5);
    chk("lat_back_idle", 32'(m_tvalid), 0);
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    step();
    chk("lat_pkt_done_pulse", 32'(pkt_done), 0);

    // back-to-back packets with lengths preloaded
    push_lens = '{3, 4, 7}; exp_lens = '{3, 4, 7}; sizes = '{6, 8, 2};
    run(1'b1, 100, 1'b0, 1'b1);

    // queue full: one length goes straight to split_len, DEPTH fill
    cfg_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cfg_len = LSIZE'(20 + k);
      @(negedge clock);
      acc = cfg_ready;
      step();
      chk($sformatf("full_acc[%0d]", k), 32'(acc), (k < 9) ? 1 : 0);
    end
    cfg_valid = 1'b0;
    chk("full_q_count", 32'(q_count), DEPTH);
    chk("full_cfg_ready", 32'(cfg_ready), 0);
    chk("full_split_len", 32'(split_len), 20);

    // push on the same cycle as a tlast pop while full
    cfg_valid = 1'b1; cfg_len = 16'd99;
    s_tvalid = 1'b1; s_tlast = 1'b1; s_tdata = 8'h5A; m_tready = 1'b1;
    @(negedge clock);
    chk("pp_cfg_ready", 32'(cfg_ready), 1);
    step();
    cfg_valid = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    chk("pp_q_count", 32'(q_count), DEPTH);
    chk("pp_split_len", 32'(split_len), 21);
    chk("pp_pkt_done", 32'(pkt_done), 1);
    chk("pp_short_pkt", 32'(short_pkt), 1);
    push_lens = {};
    exp_lens = '{21, 22, 23, 24, 25, 26, 27, 28, 99};
    sizes.delete();
    foreach (exp_lens[i]) sizes.push_back($urandom_range(1, 5));
    run(1'b1, 100, 1'b0, 1'b0);

    // backpressure: 10 beats, split 4, ready 30%
    push_lens = '{4}; exp_lens = '{4}; sizes = '{10};
    run(1'b1, 30, 1'b0, 1'b0);

    // reset mid-packet
    push_len(10); push_len(11); push_len(12);
    s_tvalid = 1'b1; s_tlast = 1'b0; m_tready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bit ok;
      s_tdata = DSIZE'(b);
      wait_hs(1'b0, ok);
      if (!ok) chk("mid_rst_beat_timeout", 0, 1);
    end
    rst_n = 1'b0;
    step();
    chk("mid_rst_m_tvalid", 32'(m_tvalid), 0);
    chk("mid_rst_q_count", 32'(q_count), 0);
    chk("mid_rst_split_len", 32'(split_len), 0);
    rst_n = 1'b1;
    repeat (4) step();
    chk("mid_rst_idle_s_tready", 32'(s_tready), 0);
    chk("mid_rst_idle_m_tvalid", 32'(m_tvalid), 0);
    s_tvalid = 1'b0; m_tready = 1'b0;
    push_lens = '{2}; exp_lens = '{2}; sizes = '{3};
    run(1'b0, 100, 1'b0, 1'b0);

    // randomized rounds, including zero lengths and concurrent pushes
    for (int r = 0; r < 8; r++) begin
      int n;
      bit pre;
      n = $urandom_range(1, 12);
      pre = (n <= DEPTH + 1) && ($urandom_range(0, 1) == 1);
      push_lens.delete(); sizes.delete();
      for (int i = 0; i < n; i++) begin
        push_lens.push_back($urandom_range(0, 12));
        sizes.push_back($urandom_range(1, 12));
      end
      exp_lens = push_lens;
      run(pre, $urandom_range(30, 100), 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
